// File: rtl/video_timing_gen_if.sv
// Pixel request / video output bundle for video_timing_gen.
// master = timing generator side, slave = frame buffer + HDMI transmitter side.
interface video_timing_gen_if #(
    parameter int unsigned PIX_W   = 11,
    parameter int unsigned COLOR_W = 8
);
    // Handshake: pix_req/pix_x/pix_y are valid for one cycle with no ready;
    // rgb_in must carry the matching pixel exactly RD_LAT cycles later, with
    // no valid qualifier and no backpressure in either direction.
    logic                   pix_req;
    logic [PIX_W-1:0]       pix_x;
    logic [PIX_W-1:0]       pix_y;
    logic [3*COLOR_W-1:0]   rgb_in;
    logic                   hs_out;
    logic                   vs_out;
    logic                   de_out;
    logic [3*COLOR_W-1:0]   rgb_out;
    logic                   frame_start;

    modport master (
        output pix_req,
        output pix_x,
        output pix_y,
        input  rgb_in,
        output hs_out,
        output vs_out,
        output de_out,
        output rgb_out,
        output frame_start
    );

    modport slave (
        input  pix_req,
        input  pix_x,
        input  pix_y,
        output rgb_in,
        input  hs_out,
        input  vs_out,
        input  de_out,
        input  rgb_out,
        input  frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator with pixel request / return alignment.
// Optional feature: define VTG_BORDER_EN to force all-ones on the active-area border.
module video_timing_gen #(
    parameter int unsigned COORD_W = 12,
    parameter int unsigned PIX_W   = 11,
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned RD_LAT  = 1,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] h_total,
    input  logic [COORD_W-1:0] h_sync,
    input  logic [COORD_W-1:0] h_start,
    input  logic [COORD_W-1:0] h_end,
    input  logic [COORD_W-1:0] v_total,
    input  logic [COORD_W-1:0] v_sync,
    input  logic [COORD_W-1:0] v_start,
    input  logic [COORD_W-1:0] v_end,
    video_timing_gen_if.master vid
);
    // RD_LAT is expected in 1..8; stage 1 plus RD_LAT further stages line up
    // the control bits with rgb_in at the output register.
    localparam int unsigned DLY   = RD_LAT + 1;
    localparam int unsigned RGB_W = 3 * COLOR_W;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    // Shadowed timing
    logic [COORD_W-1:0] sh_h_total_q, sh_h_total_d;
    logic [COORD_W-1:0] sh_h_sync_q,  sh_h_sync_d;
    logic [COORD_W-1:0] sh_h_start_q, sh_h_start_d;
    logic [COORD_W-1:0] sh_h_end_q,   sh_h_end_d;
    logic [COORD_W-1:0] sh_v_total_q, sh_v_total_d;
    logic [COORD_W-1:0] sh_v_sync_q,  sh_v_sync_d;
    logic [COORD_W-1:0] sh_v_start_q, sh_v_start_d;
    logic [COORD_W-1:0] sh_v_end_q,   sh_v_end_d;

    // Stage 0 counters
    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic               h_last;
    logic               v_last;
    logic               frame_last;
    logic               shadow_load;

    // Raw stage 0 decode
    logic               hs_raw;
    logic               vs_raw;
    logic               act_raw;
    logic               org_raw;

    // Stage 1 coordinates
    logic [PIX_W-1:0]   pix_x_q, pix_x_d;
    logic [PIX_W-1:0]   pix_y_q, pix_y_d;

    // Delay line, index 0 is stage 1
    logic [DLY-1:0]     dly_hs_q,  dly_hs_d;
    logic [DLY-1:0]     dly_vs_q,  dly_vs_d;
    logic [DLY-1:0]     dly_act_q, dly_act_d;
    logic [DLY-1:0]     dly_org_q, dly_org_d;

    // Output stage
    logic               hs_out_q, hs_out_d;
    logic               vs_out_q, vs_out_d;
    logic               de_out_q, de_out_d;
    logic               fs_q,     fs_d;
    logic [RGB_W-1:0]   rgb_out_q, rgb_out_d;

`ifdef VTG_BORDER_EN
    logic               brd_raw;
    logic [DLY-1:0]     dly_brd_q, dly_brd_d;
`endif

    always_comb begin
        h_last     = (h_cnt_q >= sh_h_total_q);
        v_last     = (v_cnt_q >= sh_v_total_q);
        frame_last = h_last && v_last;
        h_cnt_d    = h_last ? '0 : h_cnt_q + ONE;
        v_cnt_d    = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + ONE;
        end
    end

    // Loading on the last pixel of the frame makes new timing govern the (0,0) cycle.
    always_comb begin
        shadow_load  = reset || frame_last;
        sh_h_total_d = shadow_load ? h_total : sh_h_total_q;
        sh_h_sync_d  = shadow_load ? h_sync  : sh_h_sync_q;
        sh_h_start_d = shadow_load ? h_start : sh_h_start_q;
        sh_h_end_d   = shadow_load ? h_end   : sh_h_end_q;
        sh_v_total_d = shadow_load ? v_total : sh_v_total_q;
        sh_v_sync_d  = shadow_load ? v_sync  : sh_v_sync_q;
        sh_v_start_d = shadow_load ? v_start : sh_v_start_q;
        sh_v_end_d   = shadow_load ? v_end   : sh_v_end_q;
    end

    // Empty or inverted windows fall out of the range compares as "never active".
    always_comb begin
        hs_raw  = (h_cnt_q < sh_h_sync_q);
        vs_raw  = (v_cnt_q < sh_v_sync_q);
        act_raw = (h_cnt_q >= sh_h_start_q) && (h_cnt_q < sh_h_end_q) &&
                  (v_cnt_q >= sh_v_start_q) && (v_cnt_q < sh_v_end_q);
        org_raw = (h_cnt_q == '0) && (v_cnt_q == '0);
        pix_x_d = act_raw ? PIX_W'(h_cnt_q - sh_h_start_q) : '0;
        pix_y_d = act_raw ? PIX_W'(v_cnt_q - sh_v_start_q) : '0;
    end

`ifdef VTG_BORDER_EN
    always_comb begin
        brd_raw   = act_raw &&
                    ((h_cnt_q == sh_h_start_q) || (h_cnt_q == sh_h_end_q - ONE) ||
                     (v_cnt_q == sh_v_start_q) || (v_cnt_q == sh_v_end_q - ONE));
        dly_brd_d = {dly_brd_q[DLY-2:0], brd_raw};
    end
`endif

    always_comb begin
        dly_hs_d  = {dly_hs_q[DLY-2:0],  hs_raw};
        dly_vs_d  = {dly_vs_q[DLY-2:0],  vs_raw};
        dly_act_d = {dly_act_q[DLY-2:0], act_raw};
        dly_org_d = {dly_org_q[DLY-2:0], org_raw};
    end

    // Raw sync is active-high internally; XNOR with the polarity gives the pin level.
    always_comb begin
        hs_out_d  = dly_hs_q[DLY-1] ~^ HS_POL;
        vs_out_d  = dly_vs_q[DLY-1] ~^ VS_POL;
        de_out_d  = dly_act_q[DLY-1];
        fs_d      = dly_org_q[DLY-1];
        rgb_out_d = '0;
        if (dly_act_q[DLY-1]) begin
`ifdef VTG_BORDER_EN
            rgb_out_d = dly_brd_q[DLY-1] ? '1 : vid.rgb_in;
`else
            rgb_out_d = vid.rgb_in;
`endif
        end
    end

    always_ff @(posedge clk) begin
        sh_h_total_q <= sh_h_total_d;
        sh_h_sync_q  <= sh_h_sync_d;
        sh_h_start_q <= sh_h_start_d;
        sh_h_end_q   <= sh_h_end_d;
        sh_v_total_q <= sh_v_total_d;
        sh_v_sync_q  <= sh_v_sync_d;
        sh_v_start_q <= sh_v_start_d;
        sh_v_end_q   <= sh_v_end_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            dly_hs_q  <= '0;
            dly_vs_q  <= '0;
            dly_act_q <= '0;
            dly_org_q <= '0;
            hs_out_q  <= ~HS_POL;
            vs_out_q  <= ~VS_POL;
            de_out_q  <= 1'b0;
            fs_q      <= 1'b0;
            rgb_out_q <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            dly_hs_q  <= dly_hs_d;
            dly_vs_q  <= dly_vs_d;
            dly_act_q <= dly_act_d;
            dly_org_q <= dly_org_d;
            hs_out_q  <= hs_out_d;
            vs_out_q  <= vs_out_d;
            de_out_q  <= de_out_d;
            fs_q      <= fs_d;
            rgb_out_q <= rgb_out_d;
        end
    end

`ifdef VTG_BORDER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dly_brd_q <= '0;
        end else begin
            dly_brd_q <= dly_brd_d;
        end
    end
`endif

    assign vid.pix_req     = dly_act_q[0];
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.hs_out      = hs_out_q;
    assign vid.vs_out      = vs_out_q;
    assign vid.de_out      = de_out_q;
    assign vid.rgb_out     = rgb_out_q;
    assign vid.frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two instances (RD_LAT 1 and 4) on the small test mode,
// checked cycle by cycle against hand-computed raster tables.
module tb_video_timing_gen;
    localparam int COORD_W = 12;
    localparam int PIX_W   = 11;
    localparam int COLOR_W = 8;
    localparam int RGB_W   = 3 * COLOR_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [COORD_W-1:0] h_total = 12'd9;
    logic [COORD_W-1:0] h_sync  = 12'd2;
    logic [COORD_W-1:0] h_start = 12'd3;
    logic [COORD_W-1:0] h_end   = 12'd7;
    logic [COORD_W-1:0] v_total = 12'd4;
    logic [COORD_W-1:0] v_sync  = 12'd1;
    logic [COORD_W-1:0] v_start = 12'd2;
    logic [COORD_W-1:0] v_end   = 12'd4;

    // clock / reset
    always #5 clk = ~clk;

    video_timing_gen_if #(.PIX_W(PIX_W), .COLOR_W(COLOR_W)) vid_a ();
    video_timing_gen_if #(.PIX_W(PIX_W), .COLOR_W(COLOR_W)) vid_b ();

    video_timing_gen #(
        .COORD_W(COORD_W), .PIX_W(PIX_W), .COLOR_W(COLOR_W),
        .RD_LAT(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset),
        .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
        .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
        .vid(vid_a)
    );

    video_timing_gen #(
        .COORD_W(COORD_W), .PIX_W(PIX_W), .COLOR_W(COLOR_W),
        .RD_LAT(4), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset),
        .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
        .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
        .vid(vid_b)
    );

    // Frame buffer responder: returns {x, y} for requested pixels, a junk word otherwise.
    function automatic logic [RGB_W-1:0] pix_word(input logic req, input logic [PIX_W-1:0] x,
                                                  input logic [PIX_W-1:0] y);
        return req ? {2'b00, x, y} : 24'hA5A5A5;
    endfunction

    logic [RGB_W-1:0] resp_a;
    logic [RGB_W-1:0] resp_b [4];

    always @(posedge clk) begin
        resp_a    <= pix_word(vid_a.pix_req, vid_a.pix_x, vid_a.pix_y);
        resp_b[0] <= pix_word(vid_b.pix_req, vid_b.pix_x, vid_b.pix_y);
        for (int i = 1; i < 4; i++) resp_b[i] <= resp_b[i-1];
    end

    assign vid_a.rgb_in = resp_a;
    assign vid_b.rgb_in = resp_b[3];

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    int k = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // Hand-computed active counter intervals: start index, width; rows alternate y=0,1.
    int tab_start [8];
    int tab_len   [8];
    int tab_n = 0;

    function automatic bit act_at(input int c, output int x, output int y, output int w);
        x = 0;
        y = 0;
        w = 0;
        for (int i = 0; i < tab_n; i++) begin
            if (c >= tab_start[i] && c < tab_start[i] + tab_len[i]) begin
                x = c - tab_start[i];
                y = i % 2;
                w = tab_len[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [RGB_W-1:0] exp_rgb(input bit on, input int x, input int y, input int w);
        logic [PIX_W-1:0] xv;
        logic [PIX_W-1:0] yv;
        xv = x[PIX_W-1:0];
        yv = y[PIX_W-1:0];
        if (!on) return '0;
`ifdef VTG_BORDER_EN
        if (x == 0 || x == w - 1 || y == 0 || y == 1) return '1;
`endif
        return {2'b00, xv, yv};
    endfunction

    // 10-cycle lines, 50-cycle frames; lag = cycles from counter to output pins.
    function automatic logic exp_hs(input int kk, input int lag);
        int d;
        d = kk - lag;
        if (d < 0) return 1'b1;
        return ((d % 10) < 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_vs(input int kk, input int lag);
        int d;
        d = kk - lag;
        if (d < 0) return 1'b1;
        return ((d % 50) < 10) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic exp_fs(input int kk, input int lag);
        int d;
        d = kk - lag;
        return (d >= 0) && ((d % 50) == 0);
    endfunction

    task automatic check_cycle();
        int x, y, w;
        bit on;
        on = act_at(k - 1, x, y, w);
        check_eq("a_pix_req", vid_a.pix_req, on);
        check_eq("a_pix_x", vid_a.pix_x, on ? x : 0);
        check_eq("a_pix_y", vid_a.pix_y, on ? y : 0);
        check_eq("b_pix_req", vid_b.pix_req, on);
        check_eq("b_pix_x", vid_b.pix_x, on ? x : 0);
        on = act_at(k - 3, x, y, w);
        check_eq("a_de", vid_a.de_out, on);
        check_eq("a_rgb", vid_a.rgb_out, exp_rgb(on, x, y, w));
        check_eq("a_hs", vid_a.hs_out, exp_hs(k, 3));
        check_eq("a_vs", vid_a.vs_out, exp_vs(k, 3));
        check_eq("a_fs", vid_a.frame_start, exp_fs(k, 3));
        on = act_at(k - 6, x, y, w);
        check_eq("b_de", vid_b.de_out, on);
        check_eq("b_rgb", vid_b.rgb_out, exp_rgb(on, x, y, w));
        check_eq("b_hs", vid_b.hs_out, exp_hs(k, 6));
        check_eq("b_vs", vid_b.vs_out, exp_vs(k, 6));
        check_eq("b_fs", vid_b.frame_start, exp_fs(k, 6));
    endtask

    int de_a_f0    = 0;
    int hs_low_a   = 0;
    int fs_a_run0  = 0;
    int fs_b_run0  = 0;
    int fs_a_run1  = 0;

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d got=timeout exp=finish", k);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Run 0: frames 0-1 use h_end=7, frames 2-3 pick up h_end=8 written mid frame 1.
        tab_start = '{23, 33, 73, 83, 123, 133, 173, 183};
        tab_len   = '{4, 4, 4, 4, 5, 5, 5, 5};
        tab_n     = 8;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        k = 0;
        check_cycle();
        reset = 1'b0;
        for (int i = 1; i <= 185; i++) begin
            @(posedge clk);
            @(negedge clk);
            k = i;
            check_cycle();
            if (k <= 52 && vid_a.de_out) de_a_f0++;
            if (k >= 3 && k <= 52 && !vid_a.hs_out) hs_low_a++;
            if (vid_a.frame_start) fs_a_run0++;
            if (vid_b.frame_start) fs_b_run0++;
            if (k == 60) h_end = 12'd8;
        end

        // k=185 is counter (5,3): one-cycle reset from here.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tab_start = '{23, 33, 73, 83, 0, 0, 0, 0};
        tab_len   = '{5, 5, 5, 5, 0, 0, 0, 0};
        tab_n     = 4;
        k = 0;
        check_cycle();
        reset = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            k = i;
            check_cycle();
            if (vid_a.frame_start) fs_a_run1++;
        end

        check_eq("a_de_per_frame", de_a_f0, 8);
        check_eq("a_hs_low_per_frame", hs_low_a, 10);
        check_eq("a_fs_count_run0", fs_a_run0, 4);
        check_eq("b_fs_count_run0", fs_b_run0, 4);
        check_eq("a_fs_count_run1", fs_a_run1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
